// File: rtl/ub_read_sequencer_if.sv
// Burst read sequencer bus: command, host arbitration,
// unified buffer read port 0 and the downstream row stream.
interface ub_read_sequencer_if #(
  parameter int MATRIX_WIDTH = 14,
  parameter int ADDR_WIDTH   = 24,
  parameter int LEN_WIDTH    = 16
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [ADDR_WIDTH-1:0]     cmd_addr;
  logic [LEN_WIDTH-1:0]      cmd_len;
  logic                      busy;
  logic                      done;
  logic                      host_req;
  logic                      host_gnt;
  logic [ADDR_WIDTH-1:0]     ub_addr0;
  logic                      ub_en0;
  logic                      ub_enable;
  logic [MATRIX_WIDTH*8-1:0] ub_read_port0;
  logic [MATRIX_WIDTH*8-1:0] out_data;
  logic                      out_valid;
  logic                      out_last;
  logic                      out_ready;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len,
    input  host_req, ub_read_port0, out_ready,
    output cmd_ready, busy, done, host_gnt,
    output ub_addr0, ub_en0, ub_enable,
    output out_data, out_valid, out_last
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len,
    output host_req, ub_read_port0, out_ready,
    input  cmd_ready, busy, done, host_gnt,
    input  ub_addr0, ub_en0, ub_enable,
    input  out_data, out_valid, out_last
  );
endinterface

// File: rtl/ub_read_sequencer.sv
// Issues burst row reads on unified buffer port 0, tracks the
// 3-cycle read pipeline and arbitrates the port with the host.
module ub_read_sequencer #(
  parameter int MATRIX_WIDTH = 14,
  parameter int ADDR_WIDTH   = 24,
  parameter int LEN_WIDTH    = 16
) (
  input logic clk,
  input logic rst,
  ub_read_sequencer_if.master bus
);
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    HOST
  } state_t;

  state_t                    state, state_n;
  logic [ADDR_WIDTH-1:0]     addr, addr_n;
  logic [LEN_WIDTH-1:0]      rem, rem_n;
  logic [2:0]                vpipe, vpipe_n;
  logic [2:0]                lpipe, lpipe_n;
  logic                      done_q, done_n;
  logic                      stall;
  logic                      issue;
  logic                      accept;
  logic                      pipe_empty;
  logic                      last_acc;
  logic                      final_row;
  logic [MATRIX_WIDTH*8-1:0] rd_row;

  assign stall      = vpipe[2] & ~bus.out_ready;
  assign pipe_empty = ~|vpipe;
  assign final_row  = (rem == LEN_WIDTH'(1));
  assign issue      = (state == ISSUE) & ~stall
                    & ~bus.host_req;
  assign accept     = bus.cmd_valid & bus.cmd_ready;
  assign last_acc   = vpipe[2] & lpipe[2]
                    & bus.out_ready;
  assign rd_row     = bus.ub_read_port0;

  assign bus.cmd_ready = (state == IDLE) & ~bus.host_req;
  assign bus.ub_en0    = issue;
  assign bus.ub_addr0  = addr;
  assign bus.ub_enable = ~stall;
  assign bus.host_gnt  = (state == HOST);
  assign bus.busy      = (state == ISSUE)
                       | (state == DRAIN)
                       | ((state == HOST) & (rem != '0));
  assign bus.done      = done_q;
  assign bus.out_data  = rd_row;
  assign bus.out_valid = vpipe[2];
  assign bus.out_last  = lpipe[2];

  always_comb begin
    state_n = state;
    addr_n  = addr;
    rem_n   = rem;
    vpipe_n = vpipe;
    lpipe_n = lpipe;
    done_n  = 1'b0;
    // Valid/last mirror the buffer's 3-stage read pipe
    if (!stall) begin
      vpipe_n = {vpipe[1:0], issue};
      lpipe_n = {lpipe[1:0], issue & final_row};
    end
    unique case (state)
      IDLE: begin
        if (bus.host_req) begin
          if (pipe_empty) state_n = HOST;
        end else if (accept) begin
          if (bus.cmd_len == '0) begin
            done_n = 1'b1;
          end else begin
            addr_n  = bus.cmd_addr;
            rem_n   = bus.cmd_len;
            state_n = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_n = addr + ADDR_WIDTH'(1);
          rem_n  = rem - LEN_WIDTH'(1);
          if (final_row) state_n = DRAIN;
        end else if (bus.host_req && pipe_empty) begin
          state_n = HOST;
        end
      end
      DRAIN: begin
        if (last_acc) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      HOST: begin
        if (!bus.host_req) begin
          state_n = (rem != '0) ? ISSUE : IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr   <= '0;
      rem    <= '0;
      vpipe  <= '0;
      lpipe  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      addr   <= addr_n;
      rem    <= rem_n;
      vpipe  <= vpipe_n;
      lpipe  <= lpipe_n;
      done_q <= done_n;
    end
  end
endmodule

// File: doc/ub_read_sequencer.md
Name: ub_read_sequencer

Overview:
Sequences burst reads out of the unified buffer's read port 0 and arbitrates that port against host (master port) accesses. It accepts a (start address, length) command, issues one row read per cycle on addr0/en0, and tracks the 3-cycle buffer read pipeline so that each returned row leaves with a valid/last flag. The block freezes the buffer pipeline under downstream backpressure. It grants the host exclusive access only when no reads are in flight. It sits between the control unit (command source and host interface) and the unified buffer / systolic data setup path.

Parameters:
MATRIX_WIDTH, 14, row width in bytes; data width is MATRIX_WIDTH*8
ADDR_WIDTH, 24, buffer row address width (matches buffer_addr_type)
LEN_WIDTH, 16, burst length counter width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
cmd_valid  in  1  burst command valid
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_addr  in  ADDR_WIDTH  first row address
cmd_len  in  LEN_WIDTH  number of rows; 0 is legal
busy  out  1  command in progress (issuing or draining)
done  out  1  one-cycle pulse when a burst completes
host_req  in  1  host wants the master port; level, held until host_gnt is seen
host_gnt  out  1  host may drive master_en; held while host_req is high
ub_addr0  out  ADDR_WIDTH  to buffer addr0
ub_en0  out  1  to buffer en0
ub_enable  out  1  to buffer enable (pipeline advance)
ub_read_port0  in  MATRIX_WIDTH*8  from buffer read_port0
out_data  out  MATRIX_WIDTH*8  equals ub_read_port0 (pass-through)
out_valid  out  1  out_data holds a requested row
out_last  out  1  with out_valid: final row of the burst
out_ready  in  1  downstream accepts the row

Behaviour:
- States: IDLE, ISSUE, DRAIN, HOST.
- Reset values: state IDLE, counters 0, valid pipe empty, ub_en0=0, ub_addr0=0, host_gnt=0, done=0, busy=0, out_valid=0, out_last=0. ub_enable=1 and cmd_ready=1 follow combinationally.
- stall = out_valid & ~out_ready.
  - ub_enable = ~stall.
  - ub_en0 = (state==ISSUE) & ~stall & ~host_req.
  - All internal pipe and counter updates are frozen while stall is high.
- Read latency: the row addressed in the cycle where ub_en0=1 appears on ub_read_port0 exactly 3 non-stalled cycles later. A 3-stage valid/last shift register mirrors this; stage 3 drives out_valid/out_last.
- IDLE:
  - cmd_ready = ~host_req.
  - On acceptance: if cmd_len>0, latch addr/len and go to ISSUE. If cmd_len==0, pulse done next cycle and stay in IDLE.
  - If host_req is high and the pipe is empty, go to HOST.
- ISSUE:
  - Each cycle with ub_en0=1: ub_addr0 = current address, address +1, remaining −1. The issue of the final row pushes last=1 into the pipe.
  - Address wraps modulo 2^ADDR_WIDTH.
  - After the final issue, go to DRAIN.
  - If host_req rises mid-burst, issuing pauses (ub_en0=0) but the pipe keeps draining. Once the pipe is empty and the output has been accepted, go to HOST with the resume address retained.
- DRAIN: leave when the last row is accepted (out_valid & out_last & out_ready). done pulses in that same cycle's successor; return to IDLE.
- HOST:
  - host_gnt=1, ub_en0=0, ub_enable=1.
  - When host_req falls, host_gnt drops in the next cycle. Return to ISSUE if the burst is unfinished, otherwise IDLE.
  - host_gnt never rises while any valid bit is set in the pipe.
- Priority: host_req beats new command acceptance and new issues. host_req and cmd_valid arriving together in IDLE: host granted, cmd_ready=0.
- busy = state in {ISSUE, DRAIN} or HOST with an unfinished burst.
- rst at any time aborts the burst and returns to the reset values the next cycle. host_gnt drops, and in-flight rows are discarded (no out_valid).

Test Plan:
- Burst: cmd_addr=0, cmd_len=4, out_ready=1.
  - Expect ub_en0 high 4 cycles with addr 0,1,2,3.
  - Expect out_valid 3 cycles after each issue, with rows 0x7273…7F, 0x6465…71, 0x5657…63, 0x4849…55.
  - Expect out_last on the 4th row and done one cycle later.
- Backpressure: cmd_len=6, out_ready low for 5 cycles after the first out_valid.
  - Expect ub_enable=0, ub_en0=0 and out_data stable during the stall.
  - Expect all 6 rows in order, none dropped or duplicated.
- Host preemption: host_req raised after the 2nd issue of an 8-row burst.
  - Expect issuing to pause, the 2 in-flight rows to be delivered, then host_gnt=1.
  - After host_req drops, expect resume at addr 2 and 8 rows total.
- Simultaneous: cmd_valid and host_req in IDLE.
  - Expect host_gnt next cycle and cmd_ready=0.
  - Expect the command accepted after host_req drops.
- Edge cases: cmd_len=0 gives a done pulse with no ub_en0. cmd_addr=2^24−2 with cmd_len=3 gives addresses FFFFFE, FFFFFF, 000000.
- Reset: rst in the middle of a 10-row burst. Expect next cycle: IDLE, out_valid=0, busy=0, cmd_ready=1, no further ub_en0.
